sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 29 ++
 rtl/sram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_AW = 20;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic req_id_t;
  localparam req_id_t REQ_INST = 1'b0;
  localparam req_id_t REQ_DATA = 1'b1;

  // Access selected by the arbiter in IDLE, before it is latched.
  typedef struct packed {
    req_id_t                id;
    logic                   we;
    logic [BE_W-1:0]        be;
    logic [SRAM_AW-1:0]     addr;
    logic [DATA_W-1:0]      wdata;
  } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store ports onto one
// asynchronous SRAM, with fixed read wait states and write pulse width.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_i,
  input  logic [31:0]         inst_addr_i,
  output logic                inst_ack_o,
  output logic [31:0]         inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_ack_o,
  output logic [31:0]         data_rdata_o,
  output logic [SRAM_AW-1:0]  sram_addr_o,
  output logic [31:0]         sram_wdata_o,
  input  logic [31:0]         sram_rdata_i,
  output logic                sram_data_oe_o,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o,
  output logic [3:0]          sram_be_n_o
);

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  req_id_t           last_q, last_nxt;
  req_id_t           gnt_id_q;
  logic              gnt_we_q;
  grant_t            gnt_sel;
  logic              gnt_valid;

  logic                ce_n_nxt, oe_n_nxt, we_n_nxt, data_oe_nxt;
  logic [3:0]          be_n_nxt;
  logic [SRAM_AW-1:0]  addr_nxt;
  logic [31:0]         wdata_nxt;
  logic                inst_ack_nxt, data_ack_nxt;
  logic [31:0]         inst_rdata_nxt, data_rdata_nxt;

  // Byte-offset and above-SRAM address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr_i[31:SRAM_AW+2], inst_addr_i[1:0],
                              data_addr_i[31:SRAM_AW+2], data_addr_i[1:0]};

  // Arbitration: single requester wins outright, a tie goes to the one not granted last.
  always_comb begin
    gnt_sel   = '0;
    gnt_valid = 1'b0;
    if (inst_req_i && data_req_i) begin
      gnt_valid  = 1'b1;
      gnt_sel.id = (last_q == REQ_INST) ? REQ_DATA : REQ_INST;
    end else if (data_req_i) begin
      gnt_valid  = 1'b1;
      gnt_sel.id = REQ_DATA;
    end else if (inst_req_i) begin
      gnt_valid  = 1'b1;
      gnt_sel.id = REQ_INST;
    end
    if (gnt_sel.id == REQ_DATA) begin
      gnt_sel.we    = data_we_i;
      gnt_sel.be    = data_be_i;
      gnt_sel.addr  = data_addr_i[SRAM_AW+1:2];
      gnt_sel.wdata = data_wdata_i;
    end else begin
      gnt_sel.we    = 1'b0;
      gnt_sel.be    = 4'hF;
      gnt_sel.addr  = inst_addr_i[SRAM_AW+1:2];
      gnt_sel.wdata = '0;
    end
  end

  // State register, wait counter, last-grant flag and latched grant attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= REQ_INST;
      gnt_id_q <= REQ_INST;
      gnt_we_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      last_q  <= last_nxt;
      if (state_q == IDLE && gnt_valid) begin
        gnt_id_q <= gnt_sel.id;
        gnt_we_q <= gnt_sel.we;
      end
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    last_nxt  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_nxt = gnt_sel.id;
          if (gnt_sel.we) begin
            state_nxt = WR;
            cnt_nxt   = CNT_W'(WR_CYCLES - 1);
          end else begin
            state_nxt = RD;
            cnt_nxt   = CNT_W'(RD_CYCLES - 1);
          end
        end
      end
      RD, WR: begin
        if (cnt_q == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered SRAM pins, acks and read data.
  always_comb begin
    ce_n_nxt       = 1'b1;
    oe_n_nxt       = 1'b1;
    we_n_nxt       = 1'b1;
    data_oe_nxt    = 1'b0;
    be_n_nxt       = 4'hF;
    addr_nxt       = sram_addr_o;
    wdata_nxt      = sram_wdata_o;
    inst_ack_nxt   = 1'b0;
    data_ack_nxt   = 1'b0;
    inst_rdata_nxt = inst_rdata_o;
    data_rdata_nxt = data_rdata_o;

    if (state_q == IDLE && gnt_valid) begin
      addr_nxt = gnt_sel.addr;
      if (gnt_sel.we) begin
        wdata_nxt = gnt_sel.wdata;
      end
    end

    case (state_nxt)
      RD: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
        be_n_nxt = 4'h0;
      end
      WR: begin
        ce_n_nxt    = 1'b0;
        we_n_nxt    = 1'b0;
        data_oe_nxt = 1'b1;
        be_n_nxt    = (state_q == IDLE) ? ~gnt_sel.be : sram_be_n_o;
      end
      DONE: begin
        // Writes keep the chip selected and the bus driven as data hold time.
        if (gnt_we_q) begin
          ce_n_nxt    = 1'b0;
          data_oe_nxt = 1'b1;
          be_n_nxt    = sram_be_n_o;
        end
        if (gnt_id_q == REQ_INST) begin
          inst_ack_nxt = 1'b1;
        end else begin
          data_ack_nxt = 1'b1;
        end
        if (state_q == RD) begin
          if (gnt_id_q == REQ_INST) begin
            inst_rdata_nxt = sram_rdata_i;
          end else begin
            data_rdata_nxt = sram_rdata_i;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_data_oe_o <= 1'b0;
      sram_be_n_o    <= 4'hF;
      sram_addr_o    <= '0;
      sram_wdata_o   <= '0;
      inst_ack_o     <= 1'b0;
      data_ack_o     <= 1'b0;
      inst_rdata_o   <= '0;
      data_rdata_o   <= '0;
    end else begin
      sram_ce_n_o    <= ce_n_nxt;
      sram_oe_n_o    <= oe_n_nxt;
      sram_we_n_o    <= we_n_nxt;
      sram_data_oe_o <= data_oe_nxt;
      sram_be_n_o    <= be_n_nxt;
      sram_addr_o    <= addr_nxt;
      sram_wdata_o   <= wdata_nxt;
      inst_ack_o     <= inst_ack_nxt;
      data_ack_o     <= data_ack_nxt;
      inst_rdata_o   <= inst_rdata_nxt;
      data_rdata_o   <= data_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (default RD_CYCLES=2, WR_CYCLES=3).
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_ack_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        sram_data_oe_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  // SRAM read data: either a fixed per-vector word or an address-derived pattern.
  logic        use_model;
  logic [31:0] sram_rdata_tb;
  assign sram_rdata_i = use_model ? {12'h5A0, sram_addr_o} : sram_rdata_tb;

  sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_i     (inst_req_i),
    .inst_addr_i    (inst_addr_i),
    .inst_ack_o     (inst_ack_o),
    .inst_rdata_o   (inst_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_ack_o     (data_ack_o),
    .data_rdata_o   (data_rdata_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_rdata_i   (sram_rdata_i),
    .sram_data_oe_o (sram_data_oe_o),
    .sram_ce_n_o    (sram_ce_n_o),
    .sram_oe_n_o    (sram_oe_n_o),
    .sram_we_n_o    (sram_we_n_o),
    .sram_be_n_o    (sram_be_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_inst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [19:0] exp_addr;
    logic [3:0]  exp_be_n;
    int          exp_lat;
    int          exp_we_cyc;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // Hold reset two edges and check every output's reset value.
  task automatic do_reset();
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst ce_n",    32'(sram_ce_n_o),    32'd1);
    chk("rst oe_n",    32'(sram_oe_n_o),    32'd1);
    chk("rst we_n",    32'(sram_we_n_o),    32'd1);
    chk("rst be_n",    32'(sram_be_n_o),    32'hF);
    chk("rst data_oe", 32'(sram_data_oe_o), 32'd0);
    chk("rst acks",    32'({inst_ack_o, data_ack_o}), 32'd0);
    chk("rst addr",    32'(sram_addr_o),    32'd0);
    chk("rst wdata",   sram_wdata_o,        32'd0);
    chk("rst inst_rdata", inst_rdata_o,     32'd0);
    chk("rst data_rdata", data_rdata_o,     32'd0);
    rst = 1'b0;
  endtask

  // Single isolated access: latency, address, strobes, byte enables, read data.
  task automatic run_access(input vec_t v, input int idx);
    int          ack_cyc;
    int          we_cnt;
    int          be_bad;
    int          other_ack;
    logic [19:0] a1;
    logic [31:0] wd1;
    logic [31:0] rd_at_ack;
    logic        done_ok;
    ack_cyc = -1; we_cnt = 0; be_bad = 0; other_ack = 0;
    a1 = '0; wd1 = '0; rd_at_ack = '0; done_ok = 1'b0;
    use_model = 1'b0;
    sram_rdata_tb = v.rdata;
    if (v.is_inst) begin
      inst_addr_i = v.addr;
      inst_req_i  = 1'b1;
    end else begin
      data_we_i    = v.we;
      data_be_i    = v.be;
      data_addr_i  = v.addr;
      data_wdata_i = v.wdata;
      data_req_i   = 1'b1;
    end
    for (int cyc = 1; cyc <= 20 && ack_cyc < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        a1  = sram_addr_o;
        wd1 = sram_wdata_o;
      end
      if (sram_we_n_o == 1'b0) we_cnt++;
      if (cyc < v.exp_lat && sram_be_n_o !== v.exp_be_n) be_bad++;
      if ((v.is_inst ? data_ack_o : inst_ack_o) === 1'b1) other_ack++;
      if ((v.is_inst ? inst_ack_o : data_ack_o) === 1'b1) begin
        ack_cyc   = cyc;
        rd_at_ack = v.is_inst ? inst_rdata_o : data_rdata_o;
        done_ok   = v.we ? (sram_ce_n_o == 1'b0 && sram_data_oe_o == 1'b1 &&
                            sram_we_n_o == 1'b1 && sram_oe_n_o == 1'b1)
                         : (sram_we_n_o == 1'b1 && sram_oe_n_o == 1'b1);
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
      end
    end
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    chk($sformatf("v%0d ack latency", idx), 32'(ack_cyc), 32'(v.exp_lat));
    chk($sformatf("v%0d sram_addr", idx), 32'(a1), 32'(v.exp_addr));
    chk($sformatf("v%0d we_n low cycles", idx), 32'(we_cnt), 32'(v.exp_we_cyc));
    chk($sformatf("v%0d be_n wrong cycles", idx), 32'(be_bad), 32'd0);
    chk($sformatf("v%0d other ack", idx), 32'(other_ack), 32'd0);
    chk($sformatf("v%0d rdata at ack", idx), rd_at_ack, v.exp_rdata);
    chk($sformatf("v%0d done strobes", idx), 32'(done_ok), 32'd1);
    if (v.we) chk($sformatf("v%0d sram_wdata", idx), wd1, v.wdata);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d idle strobes", idx),
        32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o, sram_be_n_o}),
        32'({1'b1, 1'b1, 1'b1, 1'b0, 4'hF}));
  endtask

  initial begin
    int          d_cyc, i_cyc, both_hi, n_g, prev_cyc;
    logic [31:0] d_rd, i_rd;
    logic [19:0] a_first;

    rst = 1'b1;
    use_model = 1'b0;
    sram_rdata_tb = '0;
    inst_req_i = 1'b0; inst_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
    data_addr_i = '0; data_wdata_i = '0;

    //          inst  we    be     addr          wdata         sram rdata    exp addr   be_n  lat we  exp rdata
    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'h2402_0001, 20'h00004, 4'h0, 3, 0, 32'h2402_0001};
    vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        20'h00041, 4'hC, 4, 3, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 32'hFFC0_020B, 32'h0,        32'h1234_5678, 20'h00082, 4'h0, 3, 0, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0,        20'h00002, 4'hF, 4, 3, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h003F_FFFC, 32'h0,        32'hCAFE_F00D, 20'hFFFFF, 4'h0, 3, 0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b1, 4'h8, 32'h0040_0000, 32'h0BAD_F00D, 32'h0,        20'h00000, 4'h7, 4, 3, 32'h1234_5678};

    do_reset();
    for (int i = 0; i < 6; i++) run_access(vecs[i], i);

    // Simultaneous fetch and load straight out of reset: data first, inst 4 cycles later.
    do_reset();
    use_model   = 1'b1;
    inst_addr_i = 32'h0000_0200;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h0000_0100;
    inst_req_i  = 1'b1;
    data_req_i  = 1'b1;
    d_cyc = -1; i_cyc = -1; both_hi = 0; d_rd = '0; i_rd = '0; a_first = '0;
    for (int cyc = 1; cyc <= 20 && i_cyc < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) a_first = sram_addr_o;
      if (inst_ack_o && data_ack_o) both_hi++;
      if (data_ack_o) begin
        d_cyc = cyc; d_rd = data_rdata_o; data_req_i = 1'b0;
      end
      if (inst_ack_o) begin
        i_cyc = cyc; i_rd = inst_rdata_o; inst_req_i = 1'b0;
      end
    end
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    chk("tie first grant addr", 32'(a_first), 32'h40);
    chk("tie data ack cycle", 32'(d_cyc), 32'd3);
    chk("tie inst ack cycle", 32'(i_cyc), 32'd7);
    chk("tie data rdata", d_rd, {12'h5A0, 20'h00040});
    chk("tie inst rdata", i_rd, {12'h5A0, 20'h00080});
    chk("tie both acks", 32'(both_hi), 32'd0);
    @(posedge clk);
    #1;

    // Both held continuously: grants alternate D,I,D,I,D,I, one every 4 cycles.
    inst_req_i = 1'b1;
    data_req_i = 1'b1;
    n_g = 0; prev_cyc = 0; both_hi = 0;
    for (int cyc = 1; cyc <= 60 && n_g < 6; cyc++) begin
      @(posedge clk);
      #1;
      if (inst_ack_o && data_ack_o) both_hi++;
      if (inst_ack_o || data_ack_o) begin
        chk($sformatf("rr grant %0d is data", n_g), 32'(data_ack_o), (n_g % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("rr grant %0d rdata", n_g),
            data_ack_o ? data_rdata_o : inst_rdata_o,
            data_ack_o ? {12'h5A0, 20'h00040} : {12'h5A0, 20'h00080});
        chk($sformatf("rr grant %0d cycle", n_g), 32'(cyc - prev_cyc), (n_g == 0) ? 32'd3 : 32'd4);
        prev_cyc = cyc;
        n_g++;
        if (n_g == 6) begin
          inst_req_i = 1'b0;
          data_req_i = 1'b0;
        end
      end
    end
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    chk("rr grant count", 32'(n_g), 32'd6);
    chk("rr both acks", 32'(both_hi), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the second WR cycle aborts the store with no ack.
    use_model    = 1'b0;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h0000_0020;
    data_wdata_i = 32'h1122_3344;
    data_req_i   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort pre we_n", 32'(sram_we_n_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort we_n", 32'(sram_we_n_o), 32'd1);
    chk("abort ce_n", 32'(sram_ce_n_o), 32'd1);
    chk("abort be_n", 32'(sram_be_n_o), 32'hF);
    chk("abort data_oe", 32'(sram_data_oe_o), 32'd0);
    chk("abort ack", 32'(data_ack_o), 32'd0);
    data_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    both_hi = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk);
      #1;
      if (data_ack_o || inst_ack_o || !sram_ce_n_o) both_hi++;
    end
    chk("abort no late activity", 32'(both_hi), 32'd0);
    run_access(vecs[0], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
